// File: rtl/cci_mpf_csr_event_ctrs.sv
// Per-event counters fed by registered MPF shim event pulses.
// Supports pipelined indexed reads, per-index clear and clear-all, with a sticky overflow bit per counter.
module cci_mpf_csr_event_ctrs #(
    parameter int N_EVENTS  = 13,
    parameter int CTR_WIDTH = 48,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic [N_EVENTS-1:0]  evt_in,
    input  logic                 rd_req_valid,
    input  logic [IDX_WIDTH-1:0] rd_req_idx,
    output logic                 rd_rsp_valid,
    output logic [63:0]          rd_rsp_data,
    input  logic                 clr_valid,
    input  logic [IDX_WIDTH-1:0] clr_idx,
    input  logic                 clr_all
);

    localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

    logic [N_EVENTS-1:0]  evt_q;
    logic [N_EVENTS-1:0]  clr_hit;
    logic [N_EVENTS-1:0]  ovf;
    logic [CTR_WIDTH-1:0] ctr [N_EVENTS];

    logic                 rd_v_q;
    logic [IDX_WIDTH-1:0] rd_idx_q;
    logic [63:0]          rd_mux;

    // Out-of-range clear indices match no counter, so they fall out naturally.
    always_comb begin
        clr_hit = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            clr_hit[i] = clr_all | (clr_valid && (clr_idx == IDX_WIDTH'(i)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q <= '0;
            ovf   <= '0;
            for (int i = 0; i < N_EVENTS; i++) begin
                ctr[i] <= '0;
            end
        end else begin
            evt_q <= evt_in & ~{N_EVENTS{freeze}};
            for (int i = 0; i < N_EVENTS; i++) begin
                if (clr_hit[i]) begin
                    // An event landing with the clear still counts.
                    ctr[i] <= evt_q[i] ? CTR_ONE : '0;
                    ovf[i] <= 1'b0;
                end else if (evt_q[i]) begin
                    ctr[i] <= ctr[i] + CTR_ONE;
                    if (&ctr[i]) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (rd_idx_q == IDX_WIDTH'(i)) begin
                rd_mux[CTR_WIDTH-1:0] = ctr[i];
                rd_mux[63]            = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v_q       <= 1'b0;
            rd_idx_q     <= '0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            rd_v_q       <= rd_req_valid;
            rd_idx_q     <= rd_req_idx;
            rd_rsp_valid <= rd_v_q;
            if (rd_v_q) begin
                rd_rsp_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_csr_event_ctrs.sv
// Directed bench for cci_mpf_csr_event_ctrs: a default 48-bit instance and a 4-bit instance share all stimulus.
module tb_cci_mpf_csr_event_ctrs;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic [12:0] evt_in;
    logic        rd_req_valid;
    logic [3:0]  rd_req_idx;
    logic        clr_valid;
    logic [3:0]  clr_idx;
    logic        clr_all;

    logic        rv48, rv4;
    logic [63:0] rd48, rd4;

    int n_chk;
    int n_pass;

    cci_mpf_csr_event_ctrs #(.N_EVENTS(13), .CTR_WIDTH(48), .IDX_WIDTH(4)) dut48 (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .evt_in       (evt_in),
        .rd_req_valid (rd_req_valid),
        .rd_req_idx   (rd_req_idx),
        .rd_rsp_valid (rv48),
        .rd_rsp_data  (rd48),
        .clr_valid    (clr_valid),
        .clr_idx      (clr_idx),
        .clr_all      (clr_all)
    );

    cci_mpf_csr_event_ctrs #(.N_EVENTS(13), .CTR_WIDTH(4), .IDX_WIDTH(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .evt_in       (evt_in),
        .rd_req_valid (rd_req_valid),
        .rd_req_idx   (rd_req_idx),
        .rd_rsp_valid (rv4),
        .rd_rsp_data  (rd4),
        .clr_valid    (clr_valid),
        .clr_idx      (clr_idx),
        .clr_all      (clr_all)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one read, check the response two cycles later on both instances.
    task automatic rd(input int idx, input logic [63:0] e48, input logic [63:0] e4, input string tag);
        rd_req_valid = 1'b1;
        rd_req_idx   = 4'(idx);
        tick;
        rd_req_valid = 1'b0;
        tick;
        chk({tag, "_v48"}, 64'(rv48), 64'd1);
        chk({tag, "_v4"},  64'(rv4),  64'd1);
        chk({tag, "_d48"}, rd48, e48);
        chk({tag, "_d4"},  rd4,  e4);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        freeze = 1'b0;
        evt_in = '0;
        rd_req_valid = 1'b0;
        rd_req_idx = '0;
        clr_valid = 1'b0;
        clr_idx = '0;
        clr_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rv48), 64'd0);
        chk("rst_data", rd48, 64'd0);
        reset = 1'b0;

        // Back-to-back reads of every counter, responses two cycles later.
        for (int c = 0; c < 16; c++) begin
            rd_req_valid = (c < 13);
            rd_req_idx   = 4'(c);
            chk("b2b_valid", 64'(rv48), (c >= 2 && c < 15) ? 64'd1 : 64'd0);
            if (c >= 2 && c < 15) chk("b2b_data", rd48, 64'd0);
            tick;
        end
        rd_req_valid = 1'b0;
        rd(15, 64'd0, 64'd0, "rd_idx15");

        // Event in cycle A becomes visible in cycle A+2.
        evt_in = 13'(1) << 3;
        rd_req_valid = 1'b1;
        rd_req_idx = 4'd3;
        tick;
        evt_in = '0;
        tick;
        rd_req_valid = 1'b0;
        chk("lat_v0", 64'(rv48), 64'd1);
        chk("lat_d0", rd48, 64'd0);
        tick;
        chk("lat_v1", 64'(rv48), 64'd1);
        chk("lat_d1", rd48, 64'd1);
        tick;
        chk("lat_idle", 64'(rv48), 64'd0);

        // 100 cycles of events, 20 of them frozen.
        for (int c = 0; c < 100; c++) begin
            evt_in = 13'(1);
            freeze = (c >= 40 && c < 60);
            tick;
        end
        evt_in = '0;
        freeze = 1'b0;
        tick;
        tick;
        rd(0, 64'd80, 64'h8000_0000_0000_0000, "burst");
        rd(3, 64'd1, 64'd1, "indep3");
        rd(15, 64'd0, 64'd0, "rd_oor_busy");

        clr_valid = 1'b1;
        clr_idx = 4'd13;
        tick;
        clr_valid = 1'b0;
        rd(0, 64'd80, 64'h8000_0000_0000_0000, "clr_oor");

        clr_all = 1'b1;
        tick;
        clr_all = 1'b0;
        rd(0, 64'd0, 64'd0, "clr_all0");
        rd(3, 64'd0, 64'd0, "clr_all3");

        // 17 events wrap the 4-bit counter once.
        for (int c = 0; c < 17; c++) begin
            evt_in = 13'(1) << 5;
            tick;
        end
        evt_in = '0;
        tick;
        tick;
        rd(5, 64'd17, 64'h8000_0000_0000_0001, "ovf");
        clr_valid = 1'b1;
        clr_idx = 4'd5;
        tick;
        clr_valid = 1'b0;
        rd(5, 64'd0, 64'd0, "ovf_clr");

        // Counter 2 = 7, then clear it while an event is in evt_q.
        for (int c = 0; c < 7; c++) begin
            evt_in = 13'(1) << 2;
            tick;
        end
        evt_in = '0;
        tick;
        tick;
        rd(2, 64'd7, 64'd7, "pre7");
        evt_in = 13'(1) << 2;
        tick;
        evt_in = '0;
        clr_valid = 1'b1;
        clr_idx = 4'd2;
        rd_req_valid = 1'b1;
        rd_req_idx = 4'd2;
        tick;
        clr_valid = 1'b0;
        rd_req_valid = 1'b0;
        tick;
        chk("coll_rd_v", 64'(rv48), 64'd1);
        chk("coll_rd_d48", rd48, 64'd1);
        chk("coll_rd_d4", rd4, 64'd1);
        rd(2, 64'd1, 64'd1, "coll");

        // clr_all (with a simultaneous clr_valid) while every evt_q bit is set.
        evt_in = '1;
        tick;
        evt_in = '0;
        clr_all = 1'b1;
        clr_valid = 1'b1;
        clr_idx = 4'd0;
        tick;
        clr_all = 1'b0;
        clr_valid = 1'b0;
        for (int i = 0; i < 13; i++) rd(i, 64'd1, 64'd1, "clrall_evt");

        // Clear still works while frozen; frozen events are dropped.
        freeze = 1'b1;
        evt_in = 13'(1) << 4;
        clr_valid = 1'b1;
        clr_idx = 4'd4;
        tick;
        clr_valid = 1'b0;
        tick;
        evt_in = '0;
        rd(4, 64'd0, 64'd0, "frz_clr");
        freeze = 1'b0;

        // Async reset in the middle of in-flight reads.
        rd(1, 64'd1, 64'd1, "pre_rst");
        rd_req_valid = 1'b1;
        rd_req_idx = 4'd1;
        tick;
        rd_req_idx = 4'd2;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_v48", 64'(rv48), 64'd0);
        chk("rst_async_d48", rd48, 64'd0);
        chk("rst_async_d4", rd4, 64'd0);
        rd_req_valid = 1'b0;
        @(posedge clk);
        #4;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("rst_no_rsp", 64'(rv48), 64'd0);
        end
        for (int i = 0; i < 13; i++) rd(i, 64'd0, 64'd0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
